// File: rtl/if_fetch_queue.sv
// -----------------------------------------------------------------------------
// if_fetch_queue
//   Instruction-fetch unit sitting between instruction memory and decode.
//   Issues one fetch request at a time, predecodes unconditional branches to
//   steer the fetch PC, honours execute-stage redirects, and buffers fetched
//   instructions (with their PCs) in a small FIFO that feeds decode.
//
// Ports:
//   clk              main clock, rising edge
//   reset            asynchronous, active-low reset
//   imem_req_*       request channel to instruction memory (valid/ready/addr)
//   imem_resp_*      in-order response from memory (valid/data)
//   redirect_*       flush + new fetch target from execute
//   instr_valid/ready/instr/instr_pc   FIFO head handshake towards decode
//   fetch_pc         current fetch PC, for observability
// -----------------------------------------------------------------------------
module if_fetch_queue #(
  parameter int               ADDR_W      = 32,
  parameter int               DATA_W      = 32,
  parameter int               QUEUE_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [6:0]       BR_OPCODE   = 7'b1100000,
  parameter int               IMM_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [DATA_W-1:0] imem_resp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] fetch_pc
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic [ADDR_W-1:0] req_pc_reg, req_pc_next;
  logic              outstanding_reg, outstanding_next;
  logic              drop_reg, drop_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [PTR_W-1:0]  head_reg, head_next;
  logic [PTR_W-1:0]  tail_reg, tail_next;

  logic [DATA_W-1:0] instr_mem [QUEUE_DEPTH];
  logic [ADDR_W-1:0] pc_mem    [QUEUE_DEPTH];

  logic              req_fire;
  logic              resp_fire;
  logic              deq;
  logic              enq;
  logic              is_branch;
  logic [ADDR_W-1:0] imm_ext;

  // Requests are only offered while out of reset, with nothing in flight and
  // room in the queue for the answer, so the FIFO can never overflow.
  assign imem_req_valid = reset && !outstanding_reg && (count_reg < DEPTH_C);
  assign imem_req_addr  = fetch_pc_reg;
  assign fetch_pc       = fetch_pc_reg;

  assign instr_valid = (count_reg != '0);
  assign instr       = instr_mem[head_reg];
  assign instr_pc    = pc_mem[head_reg];

  assign req_fire  = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding is stale and ignored.
  assign resp_fire = imem_resp_valid && outstanding_reg;
  assign deq       = instr_valid && instr_ready;

  assign is_branch = (imem_resp_data[31:25] == BR_OPCODE);
  assign imm_ext   = {{(ADDR_W-IMM_W){imem_resp_data[IMM_W-1]}}, imem_resp_data[IMM_W-1:0]};

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    req_pc_next      = req_pc_reg;
    outstanding_next = outstanding_reg;
    drop_next        = drop_reg;
    count_next       = count_reg;
    head_next        = head_reg;
    tail_next        = tail_reg;
    enq              = 1'b0;

    // req_fire needs outstanding==0 and resp_fire needs outstanding==1, so
    // they never coincide.
    if (req_fire) begin
      outstanding_next = 1'b1;
      req_pc_next      = fetch_pc_reg;
    end

    if (redirect_valid) begin
      fetch_pc_next = redirect_pc;
      count_next    = '0;
      head_next     = tail_reg;
      if (resp_fire) begin
        // The in-flight request retires right here; its data is thrown away.
        outstanding_next = 1'b0;
        drop_next        = 1'b0;
      end
      // A request that stays in flight past the redirect belongs to the old
      // path, so its eventual response must be swallowed.
      if (req_fire || (outstanding_reg && !resp_fire)) begin
        drop_next = 1'b1;
      end
    end else begin
      if (resp_fire) begin
        outstanding_next = 1'b0;
        if (drop_reg) begin
          drop_next = 1'b0;
        end else begin
          enq           = 1'b1;
          fetch_pc_next = is_branch ? (req_pc_reg + imm_ext) : (req_pc_reg + ADDR_W'(4));
        end
      end
      if (deq) begin
        head_next = head_reg + 1'b1;
      end
      if (enq) begin
        tail_next = tail_reg + 1'b1;
      end
      count_next = count_reg + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_reg    <= RESET_PC;
      req_pc_reg      <= '0;
      outstanding_reg <= 1'b0;
      drop_reg        <= 1'b0;
      count_reg       <= '0;
      head_reg        <= '0;
      tail_reg        <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      req_pc_reg      <= req_pc_next;
      outstanding_reg <= outstanding_next;
      drop_reg        <= drop_next;
      count_reg       <= count_next;
      head_reg        <= head_next;
      tail_reg        <= tail_next;
    end
  end

  // Storage is cleared on reset so the head outputs read zero while empty
  // after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (enq) begin
      instr_mem[tail_reg] <= imem_resp_data;
      pc_mem[tail_reg]    <= req_pc_reg;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] fetch_pc;

  int total = 0;
  int bad   = 0;

  // memory model state
  int          budget    = 0;
  int          mem_lat   = 1;
  int          pend_cnt  = 0;
  logic [31:0] pend_addr = '0;
  logic        acc_seen  = 1'b0;
  logic [31:0] acc_addr  = '0;
  int          acc_count = 0;
  logic        br8_en    = 1'b0;
  logic [15:0] br8_imm   = '0;

  // scoreboards
  logic [31:0] exp_req [$];
  logic [31:0] exp_pc  [$];

  if_fetch_queue dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .fetch_pc        (fetch_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_req_ready = (budget != 0);

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (br8_en && a == 32'h8) return {7'b1100000, 9'd0, br8_imm};
    return {7'b0000001, 9'd0, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: requests and decode handshakes, sampled mid-cycle.
  always @(negedge clk) begin
    logic [31:0] e;
    acc_seen = imem_req_valid && imem_req_ready;
    if (acc_seen) begin
      acc_addr = imem_req_addr;
      acc_count++;
      if (exp_req.size() == 0) check("req_extra", {32'd0, imem_req_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        e = exp_req.pop_front();
        check("req_addr", {32'd0, imem_req_addr}, {32'd0, e});
        $display("req  addr=%08h", imem_req_addr);
      end
    end
    if (instr_valid && instr_ready) begin
      if (exp_pc.size() == 0) check("deq_extra", {32'd0, instr_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        e = exp_pc.pop_front();
        check("deq_pc", {32'd0, instr_pc}, {32'd0, e});
        check("deq_instr", {32'd0, instr}, {32'd0, mem_word(e)});
        $display("deq  pc=%08h instr=%08h", instr_pc, instr);
      end
    end
  end

  // Memory responder: one response mem_lat edges after acceptance.
  always @(posedge clk) begin
    #1;
    imem_resp_valid = 1'b0;
    if (acc_seen) begin
      pend_addr = acc_addr;
      pend_cnt  = mem_lat;
      if (budget > 0) budget--;
    end
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(pend_addr);
      end
    end
  end

  task automatic do_redirect(input logic [31:0] pc);
    redirect_pc    = pc;
    redirect_valid = 1'b1;
    @(posedge clk); #2;
    redirect_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(exp_pc.size() == 0 && exp_req.size() == 0 && budget == 0 && pend_cnt == 0) && n < 400) begin
      @(posedge clk); #2;
      n++;
    end
    repeat (3) @(posedge clk);
    #2;
    check({tag, "_timeout"}, {63'd0, n >= 400}, 64'd0);
    check({tag, "_drained"}, {63'd0, instr_valid}, 64'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    instr_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
    #2 reset = 1'b0;
    #1;
    check("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    check("rst_instr_valid", {63'd0, instr_valid}, 64'd0);
    check("rst_instr", {32'd0, instr}, 64'd0);
    check("rst_instr_pc", {32'd0, instr_pc}, 64'd0);
    check("rst_fetch_pc", {32'd0, fetch_pc}, 64'd0);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("rel_req_valid", {63'd0, imem_req_valid}, 64'd1);
    check("rel_req_addr", {32'd0, imem_req_addr}, 64'd0);

    // Sequential fetch, 1-cycle memory
    for (int i = 0; i < 6; i++) begin exp_req.push_back(32'(4*i)); exp_pc.push_back(32'(4*i)); end
    budget = 6;
    @(posedge clk);               // first acceptance edge
    @(negedge clk);
    check("lat_valid_e1", {63'd0, instr_valid}, 64'd0);
    @(negedge clk);
    check("lat_valid_e2", {63'd0, instr_valid}, 64'd1);
    wait_idle("seq");
    check("seq_fetch_pc", {32'd0, fetch_pc}, 64'h18);

    // Unconditional branch at 0x8, forward then backward
    br8_en = 1'b1; br8_imm = 16'h0010;
    do_redirect(32'h0);
    exp_req = '{32'h0, 32'h4, 32'h8, 32'h18, 32'h1C};
    exp_pc  = '{32'h0, 32'h4, 32'h8, 32'h18, 32'h1C};
    budget = 5;
    wait_idle("brf");
    check("brf_fetch_pc", {32'd0, fetch_pc}, 64'h20);
    br8_imm = 16'hFFF8;
    do_redirect(32'h0);
    exp_req = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h4};
    exp_pc  = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h4};
    budget = 5;
    wait_idle("brb");
    check("brb_fetch_pc", {32'd0, fetch_pc}, 64'h8);
    br8_en = 1'b0;

    // Decode stall fills the queue and stops fetch
    do_redirect(32'h0);
    instr_ready = 1'b0;
    acc_count = 0;
    for (int i = 0; i < 20; i++) begin exp_req.push_back(32'(4*i)); exp_pc.push_back(32'(4*i)); end
    budget = 20;
    repeat (10) @(posedge clk);
    #2;
    check("full_acc_count", 64'(acc_count), 64'd4);
    check("full_req_valid", {63'd0, imem_req_valid}, 64'd0);
    check("full_instr_valid", {63'd0, instr_valid}, 64'd1);
    check("full_head_pc", {32'd0, instr_pc}, 64'h0);
    instr_ready = 1'b1;
    wait_idle("full");
    check("full_fetch_pc", {32'd0, fetch_pc}, 64'h50);

    // Redirect while a request is outstanding
    do_redirect(32'h0);
    instr_ready = 1'b0; mem_lat = 3; acc_count = 0;
    exp_req = '{32'h0, 32'h4, 32'h8};
    exp_pc  = '{32'h0, 32'h4, 32'h8};
    budget = 3;
    n = 0;
    while (acc_count != 3 && n < 100) begin @(posedge clk); #2; n++; end
    check("rdo_wait", {63'd0, n >= 100}, 64'd0);
    check("rdo_pre_valid", {63'd0, instr_valid}, 64'd1);
    redirect_pc = 32'h100; redirect_valid = 1'b1;
    exp_pc.delete();
    exp_pc.push_back(32'h100); exp_pc.push_back(32'h104);
    exp_req.push_back(32'h100); exp_req.push_back(32'h104);
    budget = 2;
    @(posedge clk); #2;
    redirect_valid = 1'b0;
    check("rdo_flush_valid", {63'd0, instr_valid}, 64'd0);
    check("rdo_fetch_pc", {32'd0, fetch_pc}, 64'h100);
    instr_ready = 1'b1;
    wait_idle("rdo");

    // Redirect coinciding with a response and a dequeue
    mem_lat = 1;
    do_redirect(32'h0);
    instr_ready = 1'b0; acc_count = 0;
    exp_req = '{32'h0, 32'h4};
    exp_pc  = '{32'h0, 32'h4};
    budget = 2;
    n = 0;
    while (!(imem_resp_valid && acc_count == 2) && n < 100) begin @(posedge clk); #2; n++; end
    check("rdr_wait", {63'd0, n >= 100}, 64'd0);
    redirect_pc = 32'h200; redirect_valid = 1'b1; instr_ready = 1'b1;
    void'(exp_pc.pop_back());
    exp_pc.push_back(32'h200);
    exp_req.push_back(32'h200);
    budget = 1;
    @(posedge clk); #2;
    redirect_valid = 1'b0;
    check("rdr_flush_valid", {63'd0, instr_valid}, 64'd0);
    check("rdr_req_addr", {32'd0, imem_req_addr}, 64'h200);
    check("rdr_req_valid", {63'd0, imem_req_valid}, 64'd1);
    wait_idle("rdr");

    // Reset mid-transaction, late response afterwards
    do_redirect(32'h0);
    instr_ready = 1'b0; mem_lat = 3; acc_count = 0;
    exp_req = '{32'h0, 32'h4, 32'h8, 32'hC};
    exp_pc  = '{32'h0, 32'h4, 32'h8, 32'hC};
    budget = 4;
    n = 0;
    while (acc_count != 4 && n < 100) begin @(posedge clk); #2; n++; end
    check("mrst_wait", {63'd0, n >= 100}, 64'd0);
    check("mrst_pre_valid", {63'd0, instr_valid}, 64'd1);
    reset = 1'b0;
    exp_pc.delete();
    #1;
    check("mrst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    check("mrst_instr_valid", {63'd0, instr_valid}, 64'd0);
    check("mrst_instr", {32'd0, instr}, 64'd0);
    check("mrst_instr_pc", {32'd0, instr_pc}, 64'd0);
    check("mrst_fetch_pc", {32'd0, fetch_pc}, 64'd0);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("mrst_rel_req_addr", {32'd0, imem_req_addr}, 64'd0);
    repeat (3) @(posedge clk);
    #2;
    check("mrst_late_ignored", {63'd0, instr_valid}, 64'd0);
    mem_lat = 1; instr_ready = 1'b1;
    exp_req = '{32'h0, 32'h4};
    exp_pc  = '{32'h0, 32'h4};
    budget = 2;
    wait_idle("mrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised instruction-fetch unit; successor to the single-register fetch stage. Sits between instruction memory and decode.
- Issues fetch requests over a valid/ready memory interface and predecodes unconditional branches to redirect fetch.
- Accepts redirects from execute (taken conditional branches) and buffers fetched instructions with their PCs in a small queue with a valid/ready output to decode.

Parameters:
ADDR_W, 32, width of PC and memory address
DATA_W, 32, instruction width (must be >= 32)
QUEUE_DEPTH, 4, fetch-queue entries (power of two, >= 2)
RESET_PC, 0, fetch PC after reset
BR_OPCODE, 7'b1100000, opcode in instr[31:25] identifying an unconditional branch
IMM_W, 16, branch immediate width, taken from instr[IMM_W-1:0]

Ports:
clk  in  1  main clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  fetch address
imem_resp_valid  in  1  response data valid (in order, one per accepted request)
imem_resp_data  in  DATA_W  fetched instruction
redirect_valid  in  1  execute-stage redirect (flush)
redirect_pc  in  ADDR_W  redirect target
instr_valid  out  1  queue head valid to decode
instr_ready  in  1  decode accepts head
instr  out  DATA_W  head instruction
instr_pc  out  ADDR_W  address of head instruction
fetch_pc  out  ADDR_W  current fetch PC (debug/observability)

Behaviour:
- Reset (reset==0, async): fetch_pc=RESET_PC, queue count=0, outstanding=0, drop=0. imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0. All state is held while reset is low.
- One request outstanding at most.
- imem_req_valid=1 iff outstanding==0 && count<QUEUE_DEPTH && reset deasserted, with imem_req_addr=fetch_pc.
- Acceptance occurs when valid&&ready on a clock edge. At acceptance: outstanding<=1 and req_pc<=fetch_pc.
- Response is legal no earlier than the cycle after acceptance. A response with outstanding==0 is ignored.
- On response with drop==0:
  - Enqueue {req_pc, data}.
  - If data[31:25]==BR_OPCODE: fetch_pc <= req_pc + sext(data[IMM_W-1:0]), a byte offset with no scaling, two's-complement, wrapping modulo 2^ADDR_W.
  - Otherwise: fetch_pc <= req_pc + 4.
  - In both cases outstanding<=0.
- On response with drop==1: data is discarded, outstanding<=0, drop<=0, and fetch_pc is unchanged.
- Redirect (redirect_valid=1) has highest priority:
  - Queue flushed (count<=0); instr_valid=0 next cycle.
  - fetch_pc<=redirect_pc.
  - A response arriving in the same cycle is discarded.
  - If a request is outstanding or is accepted in the same cycle, drop<=1 and its response is discarded.
  - imem_req_valid may deassert and the address may change after a redirect even if the request was unaccepted. This is the only exception to the rule that a request is held stable until accepted.
- Queue: FIFO. Head drives instr/instr_pc/instr_valid registered-from-storage, with zero added latency from storage.
  - Dequeue on instr_valid&&instr_ready.
  - Simultaneous enqueue and dequeue is allowed at any count, including full.
  - Overflow cannot occur, because requests are gated by count<QUEUE_DEPTH.
  - Latency from response edge to instr_valid=1 is 1 cycle.
- Head-of-line: decode stalling (instr_ready=0) back-pressures fetch only once the queue is full.
- Pointers wrap modulo QUEUE_DEPTH. Count saturates logically at QUEUE_DEPTH, which is never exceeded.
- Priority per cycle: reset > redirect > response (branch/sequential) > hold.

Test Plan:
- Reset release, mem ready always, 1-cycle latency, non-branch words -> requests at 0x0,0x4,0x8,…; instr_pc follows the same sequence; instr_valid first high 2 cycles after the first acceptance.
- Unconditional branch at 0x8 with imm 0x0010 -> next request addr 0x18; with imm 0xFFF8 -> next request 0x0; the branch itself is delivered to decode with instr_pc=0x8.
- instr_ready=0 for 10 cycles -> exactly QUEUE_DEPTH (4) entries fetched, then imem_req_valid=0; on release, the entries drain in order and fetch resumes at 0x10.
- Redirect to 0x100 while a request to 0x8 is outstanding -> queue empty next cycle; the 0x8 response is discarded; next request addr 0x100; no stale instr_pc seen.
- Redirect in the same cycle as a response and as a dequeue -> response dropped, count=0, next request addr = redirect_pc.
- Reset asserted mid-transaction (outstanding=1, queue 3 full) -> outputs go to reset values immediately; after release, the first request is to RESET_PC and any late response is ignored.
